// File: rtl/comp_pkg.sv
// comp_pkg: result encoding and flag decode shared by the comparator
package comp_pkg;
  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_LT = 2'b01,
    CMP_GT = 2'b10
  } cmp_res_t;
  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_flags_t;
  function automatic cmp_flags_t cmp_decode(cmp_res_t r);
    return cmp_flags_t'{eq: r == CMP_EQ, lt: r == CMP_LT, gt: r == CMP_GT};
  endfunction
endpackage

// File: rtl/comp_cell.sv
// comp_cell: one bit of an MSB-first magnitude chain
module comp_cell (
  input  logic eq_in,
  input  logic gt_in,
  input  logic a,
  input  logic b,
  output logic eq_out,
  output logic gt_out
);
  assign eq_out = eq_in & ~(a ^ b);
  assign gt_out = gt_in | (eq_in & a & ~b);
endmodule

// File: rtl/comp.sv
// comp: registered signed/unsigned magnitude comparator; COMP_STATS_EN adds mismatch_cnt
module comp
  import comp_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             z,
  output logic             eq_q,
  output logic             lt_q,
  output logic             gt_q,
`ifdef COMP_STATS_EN
  output logic [CNT_W-1:0] mismatch_cnt,
`endif
  output logic             out_valid
);
  logic [WIDTH-1:0] ax, bx;
  logic [WIDTH:0] eq_c, gt_c;
  cmp_res_t res;
  cmp_flags_t f;
  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad
    $error("comp: illegal WIDTH or CNT_W");
  end
  assign z = a == b;
  always_comb begin
    ax = a;
    bx = b;
    ax[WIDTH-1] = a[WIDTH-1] ^ signed_mode;
    bx[WIDTH-1] = b[WIDTH-1] ^ signed_mode;
  end
  assign eq_c[WIDTH] = 1'b1;
  assign gt_c[WIDTH] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    comp_cell u_cell (
      .eq_in (eq_c[i+1]),
      .gt_in (gt_c[i+1]),
      .a     (ax[i]),
      .b     (bx[i]),
      .eq_out(eq_c[i]),
      .gt_out(gt_c[i])
    );
  end
  assign res = eq_c[0] ? CMP_EQ : gt_c[0] ? CMP_GT : CMP_LT;
  assign f = cmp_decode(res);
  always_ff @(posedge clk) begin
    if (rst) begin
      eq_q <= 1'b0;
      lt_q <= 1'b0;
      gt_q <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        eq_q <= f.eq;
        lt_q <= f.lt;
        gt_q <= f.gt;
      end
    end
  end
`ifdef COMP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) mismatch_cnt <= '0;
    else if (in_valid && !eq_c[0] && !(&mismatch_cnt)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_comp.sv
// tb_comp: scoreboard bench for comp at WIDTH=1 and WIDTH=8
module tb_comp;
  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic a1, b1, s1, v1, z1, eq1, lt1, gt1, ov1;
  logic [7:0] a8, b8;
  logic s8, v8, z8, eq8, lt8, gt8, ov8;
`ifdef COMP_STATS_EN
  logic [15:0] mc1;
  logic [1:0] mc8;
`endif
  int checks = 0;
  int failures = 0;
  exp_t q1[$];
  exp_t q8[$];
  exp_t last8;
  always #5 clk = ~clk;
  comp #(.WIDTH(1), .CNT_W(16)) u_c1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .signed_mode(s1), .in_valid(v1),
    .z(z1), .eq_q(eq1), .lt_q(lt1), .gt_q(gt1),
`ifdef COMP_STATS_EN
    .mismatch_cnt(mc1),
`endif
    .out_valid(ov1)
  );
  comp #(.WIDTH(8), .CNT_W(2)) u_c8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .signed_mode(s8), .in_valid(v8),
    .z(z8), .eq_q(eq8), .lt_q(lt8), .gt_q(gt8),
`ifdef COMP_STATS_EN
    .mismatch_cnt(mc8),
`endif
    .out_valid(ov8)
  );
  function automatic exp_t model8(logic [7:0] a, logic [7:0] b, logic s);
    logic lt, gt;
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    gt = s ? ($signed(a) > $signed(b)) : (a > b);
    return exp_t'{eq: a == b, lt: lt, gt: gt};
  endfunction
  task automatic drive1(input logic a, input logic b, input logic s, input logic v);
    a1 = a; b1 = b; s1 = s; v1 = v;
    if (v) q1.push_back(exp_t'{eq: a == b, lt: s ? (a & ~b) : (~a & b), gt: s ? (~a & b) : (a & ~b)});
  endtask
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic v);
    a8 = a; b8 = b; s8 = s; v8 = v;
    if (v) q8.push_back(model8(a, b, s));
  endtask
  task automatic test_reset();
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b0; s1 = 1'b0; v1 = 1'b1;
    a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; v8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({eq1, lt1, gt1, ov1} !== 4'b0000) begin
      failures++; $display("FAIL reset_w1 flags/valid got=%b exp=0000", {eq1, lt1, gt1, ov1});
    end
    checks++;
    if ({eq8, lt8, gt8, ov8} !== 4'b0000) begin
      failures++; $display("FAIL reset_w8 flags/valid got=%b exp=0000", {eq8, lt8, gt8, ov8});
    end
    a8 = 8'h5A; b8 = 8'h5A; #1;
    checks++;
    if (z8 !== 1'b1) begin
      failures++; $display("FAIL reset_z_indep got=%b exp=1", z8);
    end
`ifdef COMP_STATS_EN
    checks++;
    if (mc8 !== 2'd0 || mc1 !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", mc8, mc1);
    end
`endif
    v1 = 1'b0; v8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q1.delete(); q8.delete();
  endtask
  task automatic test_z();
    logic [1:0] pat [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic ez [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    v1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1 = pat[i][1]; b1 = pat[i][0];
      #1;
      checks++;
      if (z1 !== ez[i]) begin
        failures++; $display("FAIL z_w1 ab=%b got=%b exp=%b", pat[i], z1, ez[i]);
      end
      #9;
    end
  endtask
  task automatic test_width1();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      drive1(1'b1, 1'b0, i[0], 1'b1);
      @(posedge clk); #1;
      checks++;
      if (ov1 !== 1'b1 || q1.size() == 0) begin
        failures++; $display("FAIL w1_valid signed=%0d got=%b exp=1", i, ov1);
      end else begin
        e = q1.pop_front();
        checks++;
        if ({eq1, lt1, gt1} !== e) begin
          failures++; $display("FAIL w1_flags signed=%0d got=%b exp=%b", i, {eq1, lt1, gt1}, e);
        end
      end
    end
    v1 = 1'b0;
  endtask
  task automatic test_width8();
    logic [7:0] ta [6] = '{8'h80, 8'h80, 8'h5A, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] tb [6] = '{8'h7F, 8'h7F, 8'h5A, 8'h01, 8'h01, 8'hFF};
    logic ts [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive8(ta[i], tb[i], ts[i], 1'b1);
      #1;
      checks++;
      if (z8 !== (ta[i] == tb[i])) begin
        failures++; $display("FAIL w8_z idx=%0d got=%b exp=%b", i, z8, ta[i] == tb[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (ov8 !== 1'b1 || q8.size() == 0) begin
        failures++; $display("FAIL w8_valid idx=%0d got=%b exp=1", i, ov8);
      end else begin
        e = q8.pop_front();
        last8 = e;
        checks++;
        if ({eq8, lt8, gt8} !== e) begin
          failures++; $display("FAIL w8_flags idx=%0d got=%b exp=%b", i, {eq8, lt8, gt8}, e);
        end
      end
    end
    drive8(8'h01, 8'h02, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (ov8 !== 1'b0 || {eq8, lt8, gt8} !== last8) begin
      failures++; $display("FAIL w8_hold got=%b/%b exp=0/%b", ov8, {eq8, lt8, gt8}, last8);
    end
  endtask
  task automatic test_back_to_back();
    exp_t e;
    int onehot_bad = 0;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      drive8(8'($urandom_range(0, 255)), (i % 5 == 0) ? a8 : 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
      if (i % 5 == 0) begin
        b8 = a8;
        q8[q8.size()-1] = model8(a8, b8, s8);
      end
      @(posedge clk); #1;
      checks++;
      if (ov8 !== 1'b1 || q8.size() == 0) begin
        failures++; $display("FAIL b2b_valid idx=%0d got=%b exp=1", i, ov8);
      end else begin
        e = q8.pop_front();
        checks++;
        if ({eq8, lt8, gt8} !== e) begin
          failures++; $display("FAIL b2b_flags idx=%0d got=%b exp=%b", i, {eq8, lt8, gt8}, e);
        end
        if ($countones({eq8, lt8, gt8}) != 1) onehot_bad++;
      end
    end
    checks++;
    if (onehot_bad != 0) begin
      failures++; $display("FAIL b2b_onehot got=%0d exp=0", onehot_bad);
    end
    v8 = 1'b0;
  endtask
`ifdef COMP_STATS_EN
  task automatic test_stats();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(negedge clk);
    rst = 1'b1; v8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mc8 !== 2'd0) begin
      failures++; $display("FAIL stats_clear got=%0d exp=0", mc8);
    end
    @(negedge clk);
    rst = 1'b0;
    q8.delete();
    for (int i = 0; i < 5; i++) begin
      drive8(8'(i), 8'(i + 1), 1'b0, 1'b1);
      @(posedge clk); #1;
      void'(q8.pop_front());
      checks++;
      if (mc8 !== exp_cnt[i]) begin
        failures++; $display("FAIL stats_count idx=%0d got=%0d exp=%0d", i, mc8, exp_cnt[i]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive8(8'h10, 8'h11, 1'b0, 1'b1);
    @(posedge clk); #1;
    void'(q8.pop_front());
    drive8(8'h33, 8'h33, 1'b0, 1'b1);
    @(posedge clk); #1;
    void'(q8.pop_front());
    drive8(8'h01, 8'h02, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (mc8 !== 2'd1) begin
      failures++; $display("FAIL stats_unchanged got=%0d exp=1", mc8);
    end
  endtask
`endif
  initial begin
    rst = 1'b1;
    {a1, b1, s1, v1} = '0;
    {a8, b8, s8, v8} = '0;
    test_reset();
    test_z();
    test_width1();
    test_width8();
    test_back_to_back();
`ifdef COMP_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/comp.md
COMP -- requirements
Module: comp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, operand width in bits (legal 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, mismatch-counter width in bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 Port a SHALL be input, WIDTH bits: operand A.
REQ-005 Port b SHALL be input, WIDTH bits: operand B.
REQ-006 Port signed_mode SHALL be input, 1 bit: 1 = compare a/b as two's complement, 0 = unsigned.
REQ-007 Port in_valid SHALL be input, 1 bit: a/b/signed_mode qualify for the registered compare this cycle.
REQ-008 Port z SHALL be output, 1 bit: combinational equality, a == b.
REQ-009 Port eq_q SHALL be output, 1 bit: registered equal flag.
REQ-010 Port lt_q SHALL be output, 1 bit: registered a < b flag.
REQ-011 Port gt_q SHALL be output, 1 bit: registered a > b flag.
REQ-012 Port out_valid SHALL be output, 1 bit: registered flags hold a fresh result.
REQ-013 Port mismatch_cnt SHALL be output, CNT_W bits, present only with COMP_STATS_EN: count of valid unequal compares.

Function
REQ-014 z SHALL equal 1 exactly when every bit of a matches b; zero latency; independent of clk, rst, in_valid, signed_mode.
REQ-015 z SHALL never be X when a and b are fully known.
REQ-016 On a rising edge with in_valid=1 and rst=0, eq_q/lt_q/gt_q SHALL capture the comparison of the current a, b: 1-cycle latency.
REQ-017 Exactly one of eq_q, lt_q, gt_q SHALL be 1 whenever out_valid=1.
REQ-018 signed_mode=1 SHALL treat the MSB as sign, so for WIDTH=1, 1 (=-1) < 0; signed_mode=0 SHALL treat 1 > 0.
REQ-019 out_valid SHALL be the in_valid of the previous cycle; with in_valid=0, flags SHALL hold their last values and out_valid SHALL drop to 0.
REQ-020 Back-to-back in_valid SHALL yield one result per cycle, with no bubbles.

Reset
REQ-021 While rst=1 at a rising edge: eq_q=0, lt_q=0, gt_q=0, out_valid=0, mismatch_cnt=0.
REQ-022 rst SHALL take priority over a simultaneous in_valid; that input SHALL be dropped.
REQ-023 rst SHALL NOT affect z.

Configuration
REQ-024 With macro COMP_STATS_EN defined, mismatch_cnt SHALL exist and SHALL increment by 1 on each rising edge with in_valid=1, rst=0 and a != b.
REQ-025 mismatch_cnt SHALL saturate at all-ones and never wrap.
REQ-026 Without COMP_STATS_EN, the port and counter SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-027 Package comp_pkg SHALL hold the 2-bit result encoding CMP_EQ=2'b00, CMP_LT=2'b01, CMP_GT=2'b10 and the function decoding it to flags.
REQ-028 Sub-module comp_cell SHALL be a 1-bit magnitude cell (inputs eq/gt in, bits a/b; outputs eq/gt out), chained MSB-to-LSB by a generate loop.
REQ-029 Signed handling SHALL be done by inverting the MSB pair before the chain.

Verification
REQ-030 WIDTH=1: (a,b) = 00, 01, 10, 11 applied at 10 ns spacing -> z = 1, 0, 0, 1 immediately, with no clock needed.
REQ-031 WIDTH=1, unsigned, in_valid=1: a=1, b=0 -> next edge gt_q=1, lt_q=0, eq_q=0, out_valid=1; signed_mode=1 with the same inputs -> lt_q=1.
REQ-032 WIDTH=8, signed: a=8'h80, b=8'h7F -> lt_q=1; unsigned -> gt_q=1; a=b=8'h5A -> eq_q=1, z=1.
REQ-033 rst=1 together with in_valid=1, a != b -> all flags 0, out_valid=0, mismatch_cnt=0 after the edge.
REQ-034 COMP_STATS_EN, CNT_W=2: five valid unequal compares -> mismatch_cnt = 1, 2, 3, 3, 3; equal compares and in_valid=0 cycles -> unchanged.
